// File: rtl/link_msg_pkg.sv
// Shared types and defaults for the outbound link message scheduler.
// Class encoding doubles as slot index; a lower index means higher launch priority.
package link_msg_pkg;

    typedef enum logic [1:0] {
        CLS_SYNC     = 2'd0,
        CLS_NEW_GAME = 2'd1,
        CLS_MISS     = 2'd2,
        CLS_BALL     = 2'd3
    } msg_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [8:0] ball_y;
        logic [3:0] vel_x;
        logic [3:0] vel_y;
        logic       sign_y;
    } ball_payload_t;

    localparam int NUM_CLASSES = 4;
    localparam int PAYLOAD_W   = $bits(ball_payload_t);

    localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;
    localparam int DEFAULT_MAX_RETRY      = 3;
    localparam int DEFAULT_GAP_CYCLES     = 16;

    // Bit positions of the one-hot message type register.
    localparam int TYP_AYT  = 0;
    localparam int TYP_IAH  = 1;
    localparam int TYP_NG   = 2;
    localparam int TYP_MISS = 3;
    localparam int TYP_BALL = 4;
    localparam int TYP_W    = 5;

    function automatic msg_class_t highest_pending(input logic [NUM_CLASSES-1:0] full);
        msg_class_t cls;
        if (full[CLS_SYNC])          cls = CLS_SYNC;
        else if (full[CLS_NEW_GAME]) cls = CLS_NEW_GAME;
        else if (full[CLS_MISS])     cls = CLS_MISS;
        else                         cls = CLS_BALL;
        return cls;
    endfunction

endpackage

// File: rtl/msg_slot.sv
// One-deep message holding register: a set always loads the newest payload,
// and a set landing on an occupied slot that is not being drained pulses overwrite.
module msg_slot #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset_L,
    input  logic         set,
    input  logic         clear,
    input  logic [W-1:0] data_in,
    output logic         full,
    output logic [W-1:0] data,
    output logic         overwrite
);

    logic         full_reg;
    logic [W-1:0] data_reg;
    logic         overwrite_reg;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            full_reg      <= 1'b0;
            data_reg      <= '0;
            overwrite_reg <= 1'b0;
        end else begin
            overwrite_reg <= set && full_reg && !clear;
            if (set) begin
                full_reg <= 1'b1;
                data_reg <= data_in;
            end else if (clear) begin
                full_reg <= 1'b0;
            end
        end
    end

    assign full      = full_reg;
    assign data      = data_reg;
    assign overwrite = overwrite_reg;

endmodule

// File: rtl/tx_message_scheduler.sv
// Arbitrates SYNC / NEW_GAME / MISS / BALL requests onto the single sender
// handshake, with inter-message gap, send timeout, bounded retry and link failure flag.
module tx_message_scheduler
    import link_msg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = DEFAULT_MAX_RETRY,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       req_sync,
    input  logic       sync_kind_in,
    input  logic       req_new_game,
    input  logic       req_miss,
    input  logic       i_lost_in,
    input  logic       req_ball,
    input  logic [8:0] ball_y_in,
    input  logic [3:0] vel_x_in,
    input  logic [3:0] vel_y_in,
    input  logic       sign_y_in,
    input  logic       message_sent,
    input  logic       clear_fail,
    output logic       send_new_message,
    output logic       are_you_there_tx,
    output logic       I_am_here_tx,
    output logic       new_game_message_tx,
    output logic       miss_message_tx,
    output logic       ball_message_tx,
    output logic       I_lost_tx,
    output logic [8:0] ball_y_tx,
    output logic [3:0] velocity_x_tx,
    output logic [3:0] velocity_y_tx,
    output logic       sign_y_tx,
    output logic [3:0] pending,
    output logic       busy,
    output logic [3:0] overwrite,
    output logic       tx_timeout,
    output logic       link_fail
);

    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    logic [NUM_CLASSES-1:0] req_vec;
    logic [NUM_CLASSES-1:0] slot_full;
    logic [NUM_CLASSES-1:0] slot_clear;
    logic [NUM_CLASSES-1:0] slot_overwrite;
    logic [PAYLOAD_W-1:0]   slot_in   [NUM_CLASSES];
    logic [PAYLOAD_W-1:0]   slot_data [NUM_CLASSES];

    sched_state_t          state_reg, state_next;
    msg_class_t            cls_reg;
    msg_class_t            sel_cls;
    logic [PAYLOAD_W-1:0]  sel_payload;
    logic [TYP_W-1:0]      type_reg, type_next;
    logic [TO_W-1:0]       to_cnt_reg;
    logic [RT_W-1:0]       retry_reg;
    logic [GAP_W-1:0]      gap_cnt_reg;
    logic                  dirty_reg;
    logic                  i_lost_reg;
    ball_payload_t         ball_reg;
    logic                  tx_timeout_reg;
    logic                  link_fail_reg;

    logic sent_ok;
    logic timeout_hit;
    logic drop;
    logic gap_done;

    assign req_vec = {req_ball, req_miss, req_new_game, req_sync};

    assign slot_in[CLS_SYNC]     = {{(PAYLOAD_W-1){1'b0}}, sync_kind_in};
    assign slot_in[CLS_NEW_GAME] = '0;
    assign slot_in[CLS_MISS]     = {{(PAYLOAD_W-1){1'b0}}, i_lost_in};
    assign slot_in[CLS_BALL]     = {ball_y_in, vel_x_in, vel_y_in, sign_y_in};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_slot
            msg_slot #(
                .W(PAYLOAD_W)
            ) u_slot (
                .clock     (clock),
                .reset_L   (reset_L),
                .set       (req_vec[gi]),
                .clear     (slot_clear[gi]),
                .data_in   (slot_in[gi]),
                .full      (slot_full[gi]),
                .data      (slot_data[gi]),
                .overwrite (slot_overwrite[gi])
            );
        end
    endgenerate

    assign sel_cls     = highest_pending(slot_full);
    assign sel_payload = slot_data[sel_cls];

    assign sent_ok     = (state_reg == ST_SEND) && message_sent;
    assign timeout_hit = (state_reg == ST_SEND) && !message_sent
                         && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign drop        = timeout_hit && (retry_reg == RT_W'(MAX_RETRY));
    assign gap_done    = (state_reg == ST_GAP) && (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));

    // A slot refreshed while its previous payload was in flight must survive
    // the completion so the newer payload still gets sent.
    always_comb begin
        slot_clear = '0;
        if ((sent_ok || drop) && !dirty_reg)
            slot_clear[cls_reg] = 1'b1;
    end

    always_comb begin
        type_next = '0;
        case (sel_cls)
            CLS_SYNC: begin
                if (sel_payload[0]) type_next[TYP_IAH] = 1'b1;
                else                type_next[TYP_AYT] = 1'b1;
            end
            CLS_NEW_GAME: type_next[TYP_NG]   = 1'b1;
            CLS_MISS:     type_next[TYP_MISS] = 1'b1;
            default:      type_next[TYP_BALL] = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (|slot_full) state_next = ST_SEND;
            ST_SEND: if (message_sent || timeout_hit) state_next = ST_GAP;
            ST_GAP:  if (gap_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cls_reg        <= CLS_SYNC;
            type_reg       <= '0;
            to_cnt_reg     <= '0;
            retry_reg      <= '0;
            gap_cnt_reg    <= '0;
            dirty_reg      <= 1'b0;
            i_lost_reg     <= 1'b0;
            ball_reg       <= '0;
            tx_timeout_reg <= 1'b0;
            link_fail_reg  <= 1'b0;
        end else begin
            tx_timeout_reg <= timeout_hit;

            if (drop)            link_fail_reg <= 1'b1;
            else if (clear_fail) link_fail_reg <= 1'b0;

            if (state_reg == ST_GAP && !gap_done) gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            else                                  gap_cnt_reg <= '0;

            case (state_reg)
                ST_IDLE: begin
                    to_cnt_reg <= '0;
                    if (|slot_full) begin
                        cls_reg   <= sel_cls;
                        type_reg  <= type_next;
                        dirty_reg <= 1'b0;
                        if (sel_cls == CLS_MISS) i_lost_reg <= sel_payload[0];
                        if (sel_cls == CLS_BALL) ball_reg   <= ball_payload_t'(sel_payload);
                    end
                end
                ST_SEND: begin
                    if (req_vec[cls_reg]) dirty_reg <= 1'b1;
                    if (message_sent) begin
                        retry_reg <= '0;
                    end else if (timeout_hit) begin
                        retry_reg <= drop ? '0 : retry_reg + RT_W'(1);
                    end else if (to_cnt_reg != {TO_W{1'b1}}) begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset drops the
    // request and type bits without waiting for a clock edge.
    always_comb begin
        send_new_message = (state_reg == ST_SEND);
        busy             = (state_reg != ST_IDLE);
        are_you_there_tx    = send_new_message && type_reg[TYP_AYT];
        I_am_here_tx        = send_new_message && type_reg[TYP_IAH];
        new_game_message_tx = send_new_message && type_reg[TYP_NG];
        miss_message_tx     = send_new_message && type_reg[TYP_MISS];
        ball_message_tx     = send_new_message && type_reg[TYP_BALL];
    end

    assign I_lost_tx     = i_lost_reg;
    assign ball_y_tx     = ball_reg.ball_y;
    assign velocity_x_tx = ball_reg.vel_x;
    assign velocity_y_tx = ball_reg.vel_y;
    assign sign_y_tx     = ball_reg.sign_y;

    assign pending    = {slot_full[CLS_SYNC], slot_full[CLS_NEW_GAME],
                         slot_full[CLS_MISS], slot_full[CLS_BALL]};
    assign overwrite  = {slot_overwrite[CLS_SYNC], slot_overwrite[CLS_NEW_GAME],
                         slot_overwrite[CLS_MISS], slot_overwrite[CLS_BALL]};
    assign tx_timeout = tx_timeout_reg;
    assign link_fail  = link_fail_reg;

endmodule

// File: tb/tb_tx_message_scheduler.sv
// Directed bench for tx_message_scheduler: table of single-message vectors
// plus hand sequences for priority, overwrite, timeout/retry, reset and gap.
module tb_tx_message_scheduler;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       req_sync = 1'b0, sync_kind_in = 1'b0, req_new_game = 1'b0;
    logic       req_miss = 1'b0, i_lost_in = 1'b0, req_ball = 1'b0;
    logic [8:0] ball_y_in = '0;
    logic [3:0] vel_x_in = '0, vel_y_in = '0;
    logic       sign_y_in = 1'b0, message_sent = 1'b0, clear_fail = 1'b0;

    logic       send_new_message, are_you_there_tx, I_am_here_tx, new_game_message_tx;
    logic       miss_message_tx, ball_message_tx, I_lost_tx;
    logic [8:0] ball_y_tx;
    logic [3:0] velocity_x_tx, velocity_y_tx;
    logic       sign_y_tx;
    logic [3:0] pending, overwrite;
    logic       busy, tx_timeout, link_fail;
    logic [4:0] types;
    logic [17:0] ball_out;

    tx_message_scheduler #(
        .TIMEOUT_CYCLES(8),
        .MAX_RETRY     (2),
        .GAP_CYCLES    (16)
    ) dut (
        .clock              (clock),
        .reset_L            (reset_L),
        .req_sync           (req_sync),
        .sync_kind_in       (sync_kind_in),
        .req_new_game       (req_new_game),
        .req_miss           (req_miss),
        .i_lost_in          (i_lost_in),
        .req_ball           (req_ball),
        .ball_y_in          (ball_y_in),
        .vel_x_in           (vel_x_in),
        .vel_y_in           (vel_y_in),
        .sign_y_in          (sign_y_in),
        .message_sent       (message_sent),
        .clear_fail         (clear_fail),
        .send_new_message   (send_new_message),
        .are_you_there_tx   (are_you_there_tx),
        .I_am_here_tx       (I_am_here_tx),
        .new_game_message_tx(new_game_message_tx),
        .miss_message_tx    (miss_message_tx),
        .ball_message_tx    (ball_message_tx),
        .I_lost_tx          (I_lost_tx),
        .ball_y_tx          (ball_y_tx),
        .velocity_x_tx      (velocity_x_tx),
        .velocity_y_tx      (velocity_y_tx),
        .sign_y_tx          (sign_y_tx),
        .pending            (pending),
        .busy               (busy),
        .overwrite          (overwrite),
        .tx_timeout         (tx_timeout),
        .link_fail          (link_fail)
    );

    assign types    = {ball_message_tx, miss_message_tx, new_game_message_tx, I_am_here_tx, are_you_there_tx};
    assign ball_out = {ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx};

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] req;       // {sync, new_game, miss, ball}
        logic       kind;
        logic       lost;
        logic [8:0] y;
        logic [3:0] vx;
        logic [3:0] vy;
        logic       sy;
        logic [4:0] exp_type;  // {ball, miss, new_game, I_am_here, are_you_there}
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drop_reqs();
        req_sync = 1'b0; req_new_game = 1'b0; req_miss = 1'b0; req_ball = 1'b0;
    endtask

    task automatic ack();
        message_sent = 1'b1;
        tick();
        message_sent = 1'b0;
    endtask

    task automatic set_ball(input logic [8:0] y, input logic [3:0] vx, input logic [3:0] vy, input logic sy);
        req_ball = 1'b1; ball_y_in = y; vel_x_in = vx; vel_y_in = vy; sign_y_in = sy;
    endtask

    // Called right after the edge that entered GAP: 16 quiet GAP cycles, then idle.
    task automatic finish_gap(input string name);
        logic quiet;
        quiet = 1'b1;
        repeat (15) begin
            tick();
            if (send_new_message || types != 5'd0) quiet = 1'b0;
        end
        check({name, "_gap_busy"}, busy, 1);
        check({name, "_gap_quiet"}, quiet, 1);
        tick();
        check({name, "_gap_end_idle"}, busy, 0);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        req_sync = v.req[3]; sync_kind_in = v.kind;
        req_new_game = v.req[2];
        req_miss = v.req[1]; i_lost_in = v.lost;
        req_ball = v.req[0]; ball_y_in = v.y; vel_x_in = v.vx; vel_y_in = v.vy; sign_y_in = v.sy;
        tick();
        drop_reqs();
        check({nm, "_pending"}, pending, v.req);
        check({nm, "_send_not_yet"}, send_new_message, 0);
        tick();
        check({nm, "_send"}, send_new_message, 1);
        check({nm, "_type"}, types, v.exp_type);
        if (v.exp_type[4]) check({nm, "_ball_payload"}, ball_out, {v.y, v.vx, v.vy, v.sy});
        if (v.exp_type[3]) check({nm, "_i_lost"}, I_lost_tx, v.lost);
        repeat (4) tick();
        check({nm, "_type_held"}, types, v.exp_type);
        ack();
        check({nm, "_pending_after_ack"}, pending, 0);
        check({nm, "_send_after_ack"}, send_new_message, 0);
        finish_gap(nm);
        $display("vec%0d req=%b type=%b done", idx, v.req, v.exp_type);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_to;
        int to_at_fail;
        logic [3:0] pend_at_fail;

        vecs[0] = '{4'b0001, 1'b0, 1'b0, 9'd200, 4'd3,  4'd2,  1'b1, 5'b10000};
        vecs[1] = '{4'b1000, 1'b0, 1'b0, 9'd0,   4'd0,  4'd0,  1'b0, 5'b00001};
        vecs[2] = '{4'b1000, 1'b1, 1'b0, 9'd0,   4'd0,  4'd0,  1'b0, 5'b00010};
        vecs[3] = '{4'b0100, 1'b0, 1'b0, 9'd0,   4'd0,  4'd0,  1'b0, 5'b00100};
        vecs[4] = '{4'b0010, 1'b0, 1'b1, 9'd0,   4'd0,  4'd0,  1'b0, 5'b01000};
        vecs[5] = '{4'b0010, 1'b0, 1'b0, 9'd0,   4'd0,  4'd0,  1'b0, 5'b01000};
        vecs[6] = '{4'b0001, 1'b0, 1'b0, 9'd511, 4'd15, 4'd0,  1'b0, 5'b10000};
        vecs[7] = '{4'b0001, 1'b0, 1'b0, 9'd0,   4'd0,  4'd15, 1'b1, 5'b10000};

        // Reset state
        #12;
        check("reset_send", send_new_message, 0);
        check("reset_types", types, 0);
        check("reset_pending", pending, 0);
        check("reset_busy", busy, 0);
        check("reset_flags", {overwrite, tx_timeout, link_fail}, 0);
        check("reset_payload", {ball_out, I_lost_tx}, 0);
        #10 reset_L = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

        // Same-cycle SYNC(I_am_here) and BALL: SYNC first, BALL after the gap
        req_sync = 1'b1; sync_kind_in = 1'b1;
        set_ball(9'd123, 4'd5, 4'd6, 1'b0);
        tick();
        drop_reqs();
        check("prio_pending", pending, 4'b1001);
        tick();
        check("prio_first_type", types, 5'b00010);
        ack();
        check("prio_pending_ball_left", pending, 4'b0001);
        finish_gap("prio");
        tick();
        check("prio_second_type", types, 5'b10000);
        check("prio_second_payload", ball_out, {9'd123, 4'd5, 4'd6, 1'b0});
        ack();
        finish_gap("prio2");
        $display("priority sequence done");

        // Overwrite of the in-flight BALL slot
        set_ball(9'd200, 4'd3, 4'd2, 1'b1);
        tick();
        drop_reqs();
        tick();
        check("ovw_first_y", ball_y_tx, 200);
        set_ball(9'd50, 4'd1, 4'd1, 1'b0);
        tick();
        drop_reqs();
        check("ovw_pulse", overwrite, 4'b0001);
        check("ovw_outputs_frozen", ball_out, {9'd200, 4'd3, 4'd2, 1'b1});
        tick();
        check("ovw_pulse_one_cycle", overwrite, 4'b0000);
        ack();
        check("ovw_slot_kept", pending, 4'b0001);
        finish_gap("ovw");
        tick();
        check("ovw_resend_type", types, 5'b10000);
        check("ovw_resend_payload", ball_out, {9'd50, 4'd1, 4'd1, 1'b0});
        ack();
        check("ovw_pending_clear", pending, 0);
        finish_gap("ovw2");
        $display("overwrite sequence done");

        // MISS queued while NEW_GAME in flight
        req_new_game = 1'b1;
        tick();
        drop_reqs();
        tick();
        check("miss_ng_type", types, 5'b00100);
        req_miss = 1'b1; i_lost_in = 1'b1;
        tick();
        drop_reqs(); i_lost_in = 1'b0;
        check("miss_ng_pending", pending, 4'b0110);
        ack();
        check("miss_ng_pending_after", pending, 4'b0010);
        finish_gap("miss_ng");
        tick();
        check("miss_type", types, 5'b01000);
        check("miss_i_lost", I_lost_tx, 1);
        ack();
        finish_gap("miss");
        $display("miss-after-new-game sequence done");

        // Sender never acknowledges: three aborts, then drop and link_fail
        set_ball(9'd77, 4'd7, 4'd7, 1'b1);
        tick();
        drop_reqs();
        n_to = 0; to_at_fail = -1; pend_at_fail = 4'hf;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (tx_timeout) n_to++;
            if (link_fail && to_at_fail < 0) begin
                to_at_fail   = n_to;
                pend_at_fail = pending;
            end
        end
        check("to_pulse_count", n_to, 3);
        check("to_fail_on_third", to_at_fail, 3);
        check("to_slot_dropped", pend_at_fail, 0);
        check("to_link_fail", link_fail, 1);
        check("to_idle", busy, 0);
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        check("to_clear_fail", link_fail, 0);
        $display("timeout sequence: %0d aborts", n_to);

        // Asynchronous reset in the middle of a handshake
        req_sync = 1'b1; sync_kind_in = 1'b0;
        req_miss = 1'b1; i_lost_in = 1'b0;
        tick();
        drop_reqs();
        tick();
        check("rst_pre_type", types, 5'b00001);
        #3 reset_L = 1'b0;
        #1;
        check("rst_send_low", send_new_message, 0);
        check("rst_types_low", types, 0);
        check("rst_pending_clear", pending, 0);
        check("rst_busy_low", busy, 0);
        #2 reset_L = 1'b1;
        tick();
        tick();
        check("rst_stays_idle", {busy, pending}, 0);
        $display("async reset sequence done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
